// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART frame controller wrapping start/parity/stop around a shift serializer.
// Revision : 1.0
// ============================================================================
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] ser_pdata,
    output logic             ser_en,
    input  logic             ser_data,
    input  logic             ser_done,
    output logic             TX,
    output logic             busy,
    output logic             tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_hold_data;
    logic [WIDTH-1:0] r_active;
    logic             r_hold_valid;
    logic             r_par_en;
    logic             r_par_typ;
    logic             w_accept;
    logic             w_pop;

    assign in_ready  = !r_hold_valid;
    assign w_accept  = in_valid && !r_hold_valid;
    assign ser_pdata = r_hold_data;
    // Every entry into START consumes the holding register.
    assign w_pop     = (w_next_state == START);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_active     <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_active     <= r_hold_data;
                r_par_en     <= PAR_EN;
                r_par_typ    <= PAR_TYP;
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold_data  <= in_data;
                r_hold_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        TX           = 1'b1;
        ser_en       = 1'b0;
        busy         = 1'b1;
        tx_done      = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (r_hold_valid) begin
                    w_next_state = START;
                end
            end
            START: begin
                TX           = 1'b0;
                ser_en       = 1'b1;
                w_next_state = DATA;
            end
            DATA: begin
                TX     = ser_data;
                ser_en = 1'b1;
                if (ser_done) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                // Odd parity is the inverse of the data XOR-reduction.
                TX           = (^r_active) ^ r_par_typ;
                w_next_state = STOP;
            end
            STOP: begin
                tx_done      = 1'b1;
                w_next_state = r_hold_valid ? START : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl with a bit-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] ser_pdata;
    logic       ser_en;
    logic       ser_data;
    logic       ser_done;
    logic       TX;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_pdata (ser_pdata),
        .ser_en    (ser_en),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .TX        (TX),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 CLK = ~CLK;

    // Serializer: loads while disabled, shifts LSB first while enabled.
    logic [7:0] sr = 8'h00;
    int         scnt = 0;
    logic       ser_q = 1'b0;
    logic       spur = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sr    <= 8'h00;
            scnt  <= 0;
            ser_q <= 1'b0;
        end else if (!ser_en) begin
            sr   <= ser_pdata;
            scnt <= 0;
        end else begin
            ser_q <= sr[0];
            sr    <= sr >> 1;
            scnt  <= scnt + 1;
        end
    end
    assign ser_data = ser_q;
    assign ser_done = (scnt == 8) || spur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of line bits still to be sent for the frame in flight.
    typedef struct packed {
        logic tx;
        logic sen;
        logic done;
    } ent_t;

    ent_t       mq[$];
    logic       m_hv = 1'b0;
    logic [7:0] m_hd = 8'h00;
    logic       m_start;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mq.delete();
            m_hv = 1'b0;
            m_hd = 8'h00;
        end else begin
            m_start = m_hv && (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_start) begin
                mq.push_back('{tx: 1'b0, sen: 1'b1, done: 1'b0});
                for (int i = 0; i < 8; i++) mq.push_back('{tx: m_hd[i], sen: 1'b1, done: 1'b0});
                if (PAR_EN) mq.push_back('{tx: (^m_hd) ^ PAR_TYP, sen: 1'b0, done: 1'b0});
                mq.push_back('{tx: 1'b1, sen: 1'b0, done: 1'b1});
                m_hv = 1'b0;
            end else if (in_valid && !m_hv) begin
                m_hv = 1'b1;
                m_hd = in_data;
            end
        end
    end

    always @(negedge CLK) begin
        if (mq.size() == 0) begin
            check("model_tx", TX, 1);
            check("model_busy", busy, 0);
            check("model_ser_en", ser_en, 0);
            check("model_tx_done", tx_done, 0);
        end else begin
            check("model_tx", TX, mq[0].tx);
            check("model_busy", busy, 1);
            check("model_ser_en", ser_en, mq[0].sen);
            check("model_tx_done", tx_done, mq[0].done);
        end
        check("model_in_ready", in_ready, !m_hv);
    end

    // Frame length / back-to-back monitor.
    int   frame_lens[$];
    int   cur_len = 0;
    int   b2b = 0;
    logic prev_done = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            cur_len   = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) cur_len++;
            if (tx_done) begin
                frame_lens.push_back(cur_len);
                cur_len = 0;
            end
            if (prev_done && busy) b2b++;
            prev_done = tx_done;
        end
    end

    logic rand_par = 1'b0;

    task automatic tick();
        @(negedge CLK);
        if (rand_par) begin
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
        end
    endtask

    task automatic push(input logic [7:0] d, output int waited);
        waited   = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && waited < 40) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: byte %0h not accepted within %0d cycles", d, waited);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !in_ready) && n < 60) begin
            tick();
            n++;
        end
        if (busy || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b in_ready=%0b after %0d cycles", busy, in_ready, n);
        end
        tick();
    endtask

    typedef struct packed {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [0:10] seq;
        logic [3:0]  len;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int w;
        int nbusy = 0;
        int ndone = 0;
        PAR_EN  = v.pe;
        PAR_TYP = v.pt;
        push(v.data, w);
        check("load_cycle_tx", TX, 1);
        check("load_cycle_in_ready", in_ready, 0);
        for (int i = 0; i < 11; i++) begin
            if (i < int'(v.len)) begin
                tick();
                check($sformatf("vec_%0h_bit%0d", v.data, i), TX, v.seq[i]);
                if (busy) nbusy++;
                if (tx_done) ndone++;
            end
        end
        tick();
        check("vec_end_busy", busy, 0);
        check("vec_busy_cycles", nbusy, v.len);
        check("vec_tx_done_cycles", ndone, 1);
    endtask

    vec_t vecs[6];
    int   w;
    int   b0;

    initial begin
        // Sequences are written in line order: start, data LSB first, parity, stop.
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 4'd11};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 11'b01010010111, 4'd11};
        vecs[2] = '{8'h07, 1'b0, 1'b0, 11'b01110000010, 4'd10};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 11'b00011110010, 4'd10};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 11'b01111111111, 4'd11};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 11'b00000000111, 4'd11};

        repeat (3) tick();
        check("rst_tx", TX, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        RST = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of a frame.
        PAR_EN = 1'b0;
        in_data = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        #2 RST = 1'b0;
        #1;
        check("async_rst_tx", TX, 1);
        check("async_rst_ser_en", ser_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_tx_done", tx_done, 0);
        repeat (2) tick();
        RST = 1'b1;
        tick();
        run_vec(vecs[3]);

        // Back-to-back: second byte offered during DATA, third stalls until its pop.
        PAR_EN = 1'b0;
        frame_lens.delete();
        b0 = b2b;
        push(8'h55, w);
        repeat (3) tick();
        push(8'h0F, w);
        check("b2b_second_wait", w, 0);
        push(8'h33, w);
        check("b2b_third_stall", w, 7);
        wait_idle();
        check("b2b_no_gap", b2b - b0, 2);
        check("b2b_frames", frame_lens.size(), 3);
        foreach (frame_lens[i]) check("b2b_len", frame_lens[i], 10);

        // Parity enable changed mid-frame only affects the following frame.
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        frame_lens.delete();
        push(8'h5A, w);
        repeat (3) tick();
        PAR_EN = 1'b0;
        push(8'hC3, w);
        wait_idle();
        check("par_toggle_frames", frame_lens.size(), 2);
        if (frame_lens.size() == 2) begin
            check("par_toggle_len0", frame_lens[0], 11);
            check("par_toggle_len1", frame_lens[1], 10);
        end

        // Spurious ser_done in IDLE and in STOP.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_idle_busy", busy, 0);
        check("spur_idle_tx", TX, 1);
        push(8'h81, w);
        w = 0;
        while (!tx_done && w < 20) begin
            tick();
            w++;
        end
        check("spur_reach_stop", tx_done, 1);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_stop_busy", busy, 0);
        check("spur_stop_tx", TX, 1);
        tick();

        // Randomized traffic with parity settings changing every cycle.
        rand_par = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 13)) tick();
            push(8'($urandom), w);
        end
        rand_par = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
